// File: rtl/mem_arb_pkg.sv
// Shared types and access codes for the unified memory port arbiter.
package mem_arb_pkg;

  // Arbiter states: one outstanding access, owned by either MA or IF.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MA_ACC = 3'd1,
    IF_ACC = 3'd2,
    MA_RSP = 3'd3,
    IF_RSP = 3'd4
  } arb_state_t;

  // Read codes: [3] = valid, [2:0] = funct3.
  localparam logic [3:0] RD_NONE = 4'b0000;
  localparam logic [3:0] RD_LB   = 4'b1000;
  localparam logic [3:0] RD_LH   = 4'b1001;
  localparam logic [3:0] RD_LW   = 4'b1010;
  localparam logic [3:0] RD_LBU  = 4'b1100;
  localparam logic [3:0] RD_LHU  = 4'b1101;

  // Write codes: [2] = valid, [1:0] = size.
  localparam logic [2:0] WR_NONE = 3'b000;
  localparam logic [2:0] WR_SB   = 3'b100;
  localparam logic [2:0] WR_SH   = 3'b101;
  localparam logic [2:0] WR_SW   = 3'b110;

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one read/write/busywait memory port between the
// instruction-fetch (IF) and data-access (MA) requesters.
//
// Optional feature macro: MEM_ARB_FAIR_EN
//   defined   - after an MA completion a waiting IF request is served next
//   undefined - strict MA priority (IF may wait while MA keeps requesting)
//
// Requester handshake: a requester raises its request (IF_REQ, or MA_READ[3] /
// MA_WRITE[2]) with stable address/data and holds it while its BUSYWAIT is
// high. The cycle in which BUSYWAIT is low with the request still high is the
// response cycle: read data is valid on IF_DATA / MA_RDATA and the requester
// advances on the following rising edge. Downstream, a nonzero MEM_READ or
// MEM_WRITE code is one access held until MEM_BUSYWAIT is seen low (from the
// second access cycle on); the codes then drop to zero for at least one cycle.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int         ADDR_WIDTH = 32,
  parameter int         DATA_WIDTH = 32,
  parameter logic [3:0] IF_RD_CODE = 4'b1010
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] IF_ADDR,
  input  logic                  IF_REQ,
  output logic [DATA_WIDTH-1:0] IF_DATA,
  output logic                  IF_BUSYWAIT,
  input  logic [ADDR_WIDTH-1:0] MA_ADDR,
  input  logic [DATA_WIDTH-1:0] MA_WDATA,
  input  logic [3:0]            MA_READ,
  input  logic [2:0]            MA_WRITE,
  output logic [DATA_WIDTH-1:0] MA_RDATA,
  output logic                  MA_BUSYWAIT,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic [DATA_WIDTH-1:0] MEM_WDATA,
  output logic [3:0]            MEM_READ,
  output logic [2:0]            MEM_WRITE,
  input  logic [DATA_WIDTH-1:0] MEM_RDATA,
  input  logic                  MEM_BUSYWAIT,
  output arb_state_t            DBG_STATE
);

  arb_state_t            r_state;
  logic                  r_first;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [3:0]            r_mem_read;
  logic [2:0]            r_mem_write;
  logic [DATA_WIDTH-1:0] r_if_data;
  logic [DATA_WIDTH-1:0] r_ma_rdata;
`ifdef MEM_ARB_FAIR_EN
  logic                  r_last_ma;
`endif

  logic       w_ma_req;
  logic       w_ma_is_wr;
  logic [3:0] w_ma_rd_code;
  logic [2:0] w_ma_wr_code;
  logic       w_if_first;
  logic       w_idle_ma;
  logic       w_idle_if;
  logic       w_grant_ma;
  logic       w_grant_if;

  // A store wins over a simultaneous load; the load code is then dropped.
  assign w_ma_req     = MA_READ[3] | MA_WRITE[2];
  assign w_ma_is_wr   = MA_WRITE[2];
  assign w_ma_rd_code = w_ma_is_wr ? RD_NONE : MA_READ;
  assign w_ma_wr_code = w_ma_is_wr ? MA_WRITE : WR_NONE;

`ifdef MEM_ARB_FAIR_EN
  // IF jumps the queue only right after an MA completion.
  assign w_if_first = r_last_ma & IF_REQ;
`else
  assign w_if_first = 1'b0;
`endif

  assign w_idle_ma = w_ma_req & ~w_if_first;
  assign w_idle_if = IF_REQ & ~w_idle_ma;

  // Grant decision. In a RSP cycle the served requester's inputs still show
  // the transaction just finished, so only the other requester can be granted
  // directly; otherwise the arbiter passes through IDLE.
  always_comb begin
    w_grant_ma = 1'b0;
    w_grant_if = 1'b0;
    case (r_state)
      IDLE: begin
        w_grant_ma = w_idle_ma;
        w_grant_if = w_idle_if;
      end
      MA_RSP:  w_grant_if = w_if_first;
      IF_RSP:  w_grant_ma = w_ma_req;
      default: ;
    endcase
  end

  // Arbitration FSM, request latches and response data registers.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state     <= IDLE;
      r_first     <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_read  <= RD_NONE;
      r_mem_write <= WR_NONE;
      r_if_data   <= '0;
      r_ma_rdata  <= '0;
`ifdef MEM_ARB_FAIR_EN
      r_last_ma   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE, MA_RSP, IF_RSP: begin
          if (w_grant_ma) begin
            r_state     <= MA_ACC;
            r_first     <= 1'b1;
            r_mem_addr  <= MA_ADDR;
            r_mem_wdata <= MA_WDATA;
            r_mem_read  <= w_ma_rd_code;
            r_mem_write <= w_ma_wr_code;
          end else if (w_grant_if) begin
            r_state     <= IF_ACC;
            r_first     <= 1'b1;
            r_mem_addr  <= IF_ADDR;
            r_mem_read  <= IF_RD_CODE;
            r_mem_write <= WR_NONE;
          end else begin
            r_state <= IDLE;
          end
        end
        MA_ACC: begin
          // Memory raises busywait one cycle late, so the first cycle is blind.
          if (r_first) begin
            r_first <= 1'b0;
          end else if (!MEM_BUSYWAIT) begin
            r_mem_read  <= RD_NONE;
            r_mem_write <= WR_NONE;
            if (r_mem_read[3]) r_ma_rdata <= MEM_RDATA;
`ifdef MEM_ARB_FAIR_EN
            r_last_ma   <= 1'b1;
`endif
            r_state     <= w_ma_req ? MA_RSP : IDLE;
          end
        end
        IF_ACC: begin
          if (r_first) begin
            r_first <= 1'b0;
          end else if (!MEM_BUSYWAIT) begin
            r_mem_read  <= RD_NONE;
            r_mem_write <= WR_NONE;
            r_if_data   <= MEM_RDATA;
`ifdef MEM_ARB_FAIR_EN
            r_last_ma   <= 1'b0;
`endif
            r_state     <= IF_REQ ? IF_RSP : IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign MEM_ADDR    = r_mem_addr;
  assign MEM_WDATA   = r_mem_wdata;
  assign MEM_READ    = r_mem_read;
  assign MEM_WRITE   = r_mem_write;
  assign IF_DATA     = r_if_data;
  assign MA_RDATA    = r_ma_rdata;
  assign DBG_STATE   = r_state;

  // Stall is combinational so a fresh request stalls in its first cycle.
  assign IF_BUSYWAIT = IF_REQ & (r_state != IF_RSP);
  assign MA_BUSYWAIT = w_ma_req & (r_state != MA_RSP);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter. Honors MEM_ARB_FAIR_EN for grant order.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  // ---------------- clock / reset / signals ----------------
  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] IF_ADDR;
  logic        IF_REQ;
  logic [31:0] IF_DATA;
  logic        IF_BUSYWAIT;
  logic [31:0] MA_ADDR;
  logic [31:0] MA_WDATA;
  logic [3:0]  MA_READ;
  logic [2:0]  MA_WRITE;
  logic [31:0] MA_RDATA;
  logic        MA_BUSYWAIT;
  logic [31:0] MEM_ADDR;
  logic [31:0] MEM_WDATA;
  logic [3:0]  MEM_READ;
  logic [2:0]  MEM_WRITE;
  logic [31:0] MEM_RDATA = '0;
  logic        MEM_BUSYWAIT = 1'b0;
  arb_state_t  DBG_STATE;

  always #5 CLK = ~CLK;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .IF_RD_CODE(4'b1010)) dut (
    .CLK(CLK), .RST(RST),
    .IF_ADDR(IF_ADDR), .IF_REQ(IF_REQ), .IF_DATA(IF_DATA), .IF_BUSYWAIT(IF_BUSYWAIT),
    .MA_ADDR(MA_ADDR), .MA_WDATA(MA_WDATA), .MA_READ(MA_READ), .MA_WRITE(MA_WRITE),
    .MA_RDATA(MA_RDATA), .MA_BUSYWAIT(MA_BUSYWAIT),
    .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .MEM_RDATA(MEM_RDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT), .DBG_STATE(DBG_STATE)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- memory environment ----------------
  // Word memory; an access is a nonzero code; busywait rises the cycle after
  // the access appears and stays high for m_pend cycles.
  logic [31:0] mem [logic [31:0]];
  int          mem_waits = 0;
  bit          mem_rand_waits = 0;
  bit          m_active = 0;
  int          m_pend = 0;
  logic [31:0] log_addr[$];
  logic [31:0] log_wdata[$];
  logic [3:0]  log_rd[$];
  logic [2:0]  log_wr[$];

  always @(negedge CLK) begin
    if ($isunknown({MEM_READ, MEM_WRITE}) || (MEM_READ == RD_NONE && MEM_WRITE == WR_NONE)) begin
      m_active     = 0;
      MEM_BUSYWAIT = 1'b0;
    end else if (!m_active) begin
      m_active     = 1;
      m_pend       = mem_rand_waits ? int'($urandom_range(0, 3)) : mem_waits;
      MEM_BUSYWAIT = 1'b0;
      log_addr.push_back(MEM_ADDR);
      log_wdata.push_back(MEM_WDATA);
      log_rd.push_back(MEM_READ);
      log_wr.push_back(MEM_WRITE);
      if (MEM_WRITE[2]) mem[MEM_ADDR] = MEM_WDATA;
      MEM_RDATA = mem.exists(MEM_ADDR) ? mem[MEM_ADDR] : 32'h0;
    end else if (m_pend > 0) begin
      MEM_BUSYWAIT = 1'b1;
      m_pend--;
    end else begin
      MEM_BUSYWAIT = 1'b0;
    end
  end

  function automatic void clear_log();
    log_addr.delete(); log_wdata.delete(); log_rd.delete(); log_wr.delete();
  endfunction

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 after the response edge.
  // lat = number of cycles BUSYWAIT was high, counting the request cycle.
  task automatic drive_if(input logic [31:0] addr, output logic [31:0] data, output int lat);
    bit done = 0;
    IF_ADDR = addr; IF_REQ = 1'b1; lat = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge CLK);
      if (!IF_BUSYWAIT) done = 1; else lat++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL if_timeout addr=%h busywait never dropped, required drop within 300 cycles", addr);
    end
    data = IF_DATA;
    @(posedge CLK); #1;
    IF_REQ = 1'b0;
  endtask

  task automatic drive_ma(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] rd,
                          input logic [2:0] wr, output logic [31:0] data, output int lat);
    bit done = 0;
    MA_ADDR = addr; MA_WDATA = wdata; MA_READ = rd; MA_WRITE = wr; lat = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge CLK);
      if (!MA_BUSYWAIT) done = 1; else lat++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL ma_timeout addr=%h busywait never dropped, required drop within 300 cycles", addr);
    end
    data = MA_RDATA;
    @(posedge CLK); #1;
    MA_READ = RD_NONE; MA_WRITE = WR_NONE;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bit done = 0;
    logic [31:0] word = $urandom;
    mem[32'h40] = word;
    RST = 1'b0; IF_REQ = 1'b1; IF_ADDR = 32'h40;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checks++; if (MEM_READ !== RD_NONE) begin errors++; $display("FAIL rst_mem_read got=%b exp=0000", MEM_READ); end
    checks++; if (MEM_WRITE !== WR_NONE) begin errors++; $display("FAIL rst_mem_write got=%b exp=000", MEM_WRITE); end
    checks++; if (MEM_ADDR !== 32'h0) begin errors++; $display("FAIL rst_mem_addr got=%h exp=0", MEM_ADDR); end
    checks++; if (IF_BUSYWAIT !== 1'b1) begin errors++; $display("FAIL rst_if_busywait got=%b exp=1", IF_BUSYWAIT); end
    checks++; if (DBG_STATE !== IDLE) begin errors++; $display("FAIL rst_state got=%0d exp=%0d", DBG_STATE, IDLE); end
    checks++; if (IF_DATA !== 32'h0 || MA_RDATA !== 32'h0) begin
      errors++; $display("FAIL rst_data if=%h ma=%h exp=0/0", IF_DATA, MA_RDATA);
    end
    @(posedge CLK); #1; RST = 1'b1;
    @(negedge CLK);
    checks++; if (MEM_READ !== RD_NONE) begin errors++; $display("FAIL rel_idle_read got=%b exp=0000", MEM_READ); end
    @(negedge CLK);
    checks++; if (MEM_READ !== 4'b1010 || MEM_ADDR !== 32'h40) begin
      errors++; $display("FAIL rel_fetch read=%b addr=%h exp=1010/00000040", MEM_READ, MEM_ADDR);
    end
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge CLK);
      if (!IF_BUSYWAIT) done = 1;
    end
    checks++; if (!done || IF_DATA !== word) begin
      errors++; $display("FAIL rel_fetch_data done=%0d got=%h exp=%h", done, IF_DATA, word);
    end
    @(posedge CLK); #1; IF_REQ = 1'b0;
  endtask

  task automatic test_if_only();
    logic [31:0] d; int lat;
    mem[32'h10] = 32'h00500093; mem_waits = 0; clear_log();
    drive_if(32'h10, d, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL if_only_latency got=%0d exp=3", lat); end
    checks++; if (d !== 32'h00500093) begin errors++; $display("FAIL if_only_data got=%h exp=00500093", d); end
    checks++; if (log_rd.size() != 1 || log_rd[0] !== 4'b1010 || log_addr[0] !== 32'h10 || log_wr[0] !== WR_NONE) begin
      errors++; $display("FAIL if_only_access count=%0d exp one read 1010 @00000010", log_rd.size());
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] d_if, d_ma; int lat_if, lat_ma;
    mem[32'h14] = 32'h00000013; clear_log();
    fork
      drive_ma(32'h100, 32'hDEADBEEF, RD_NONE, WR_SW, d_ma, lat_ma);
      drive_if(32'h14, d_if, lat_if);
    join
    checks++; if (log_wr.size() != 2) begin
      errors++; $display("FAIL sim_count got=%0d exp=2", log_wr.size());
    end else begin
      checks++; if (log_wr[0] !== WR_SW || log_rd[0] !== RD_NONE || log_addr[0] !== 32'h100 || log_wdata[0] !== 32'hDEADBEEF) begin
        errors++; $display("FAIL sim_first wr=%b rd=%b addr=%h wdata=%h exp=110/0000/100/deadbeef",
                           log_wr[0], log_rd[0], log_addr[0], log_wdata[0]);
      end
      checks++; if (log_rd[1] !== 4'b1010 || log_addr[1] !== 32'h14 || log_wr[1] !== WR_NONE) begin
        errors++; $display("FAIL sim_second rd=%b addr=%h exp=1010/00000014", log_rd[1], log_addr[1]);
      end
    end
    checks++; if (lat_ma !== 3) begin errors++; $display("FAIL sim_ma_latency got=%0d exp=3", lat_ma); end
    checks++; if (!(lat_ma < lat_if)) begin errors++; $display("FAIL sim_order ma=%0d if=%0d exp ma<if", lat_ma, lat_if); end
    checks++; if (d_if !== 32'h13) begin errors++; $display("FAIL sim_if_data got=%h exp=00000013", d_if); end
    checks++; if (d_ma !== 32'h0) begin errors++; $display("FAIL sim_store_keeps_rdata got=%h exp=0", d_ma); end
  endtask

  task automatic test_wait_states();
    logic [31:0] d; int lat;
    // Memory busy over the access cycle plus 3 stall cycles.
    mem[32'h200] = 32'h12345678; mem_waits = 3;
    drive_ma(32'h200, 32'h0, RD_LW, WR_NONE, d, lat);
    mem_waits = 0;
    checks++; if (lat !== 6) begin errors++; $display("FAIL wait_latency got=%0d exp=6", lat); end
    checks++; if (d !== 32'h12345678) begin errors++; $display("FAIL wait_data got=%h exp=12345678", d); end
    checks++; if (IF_DATA !== 32'h13) begin errors++; $display("FAIL wait_if_hold got=%h exp=00000013", IF_DATA); end
  endtask

  task automatic test_reset_mid_access();
    mem_waits = 2;
    MA_ADDR = 32'h300; MA_WDATA = 32'h55; MA_WRITE = WR_SW; MA_READ = RD_NONE;
    @(posedge CLK); @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    checks++; if (MEM_WRITE !== WR_SW) begin errors++; $display("FAIL mid_active got=%b exp=110", MEM_WRITE); end
    @(negedge CLK);
    checks++; if (MEM_WRITE !== WR_NONE) begin errors++; $display("FAIL mid_write_cleared got=%b exp=000", MEM_WRITE); end
    checks++; if (DBG_STATE !== IDLE) begin errors++; $display("FAIL mid_state got=%0d exp=%0d", DBG_STATE, IDLE); end
    checks++; if (MA_RDATA !== 32'h0 || IF_DATA !== 32'h0) begin
      errors++; $display("FAIL mid_data ma=%h if=%h exp=0/0", MA_RDATA, IF_DATA);
    end
    checks++; if (MA_BUSYWAIT !== 1'b1) begin errors++; $display("FAIL mid_busywait got=%b exp=1", MA_BUSYWAIT); end
    @(posedge CLK); #1;
    MA_WRITE = WR_NONE; RST = 1'b1; mem_waits = 0;
    @(posedge CLK); #1;
  endtask

  task automatic test_withdraw();
    bit saw_rsp = 0;
    mem[32'h400] = 32'hCAFEF00D; mem_waits = 2; clear_log();
    MA_ADDR = 32'h400; MA_READ = RD_LW;
    @(posedge CLK); @(posedge CLK); #1;
    MA_READ = RD_NONE;
    repeat (6) begin
      @(negedge CLK);
      if (DBG_STATE == MA_RSP) saw_rsp = 1;
    end
    mem_waits = 0;
    checks++; if (saw_rsp) begin errors++; $display("FAIL wd_rsp_skipped got=1 exp=0"); end
    checks++; if (log_rd.size() != 1) begin errors++; $display("FAIL wd_access_count got=%0d exp=1", log_rd.size()); end
    checks++; if (MA_RDATA !== 32'hCAFEF00D) begin errors++; $display("FAIL wd_data got=%h exp=cafef00d", MA_RDATA); end
    checks++; if (DBG_STATE !== IDLE) begin errors++; $display("FAIL wd_state got=%0d exp=%0d", DBG_STATE, IDLE); end
    @(posedge CLK); #1;
  endtask

  task automatic test_priority();
    string got = "";
    string exp;
`ifdef MEM_ARB_FAIR_EN
    exp = "MIMIMI";
`else
    exp = "MMMIII";
`endif
    clear_log();
    fork
      begin
        logic [31:0] d; int lat;
        for (int i = 0; i < 3; i++) drive_ma(32'h1000 + 32'(i) * 4, 32'(i), RD_NONE, WR_SW, d, lat);
      end
      begin
        logic [31:0] d; int lat;
        for (int i = 0; i < 3; i++) drive_if(32'h20 + 32'(i) * 4, d, lat);
      end
    join
    foreach (log_wr[i]) got = {got, (log_wr[i] != WR_NONE) ? "M" : "I"};
    checks++; if (got != exp) begin errors++; $display("FAIL grant_order got=%s exp=%s", got, exp); end
  endtask

  task automatic test_random();
    logic [31:0] if_rom [64];
    logic [31:0] ma_model [8];
    logic [3:0]  rd_codes [5];
    rd_codes[0] = RD_LB; rd_codes[1] = RD_LH; rd_codes[2] = RD_LW; rd_codes[3] = RD_LBU; rd_codes[4] = RD_LHU;
    for (int i = 0; i < 64; i++) begin if_rom[i] = $urandom; mem[32'(i) * 4] = if_rom[i]; end
    for (int i = 0; i < 8; i++) begin ma_model[i] = $urandom; mem[32'h2000 + 32'(i) * 4] = ma_model[i]; end
    mem_rand_waits = 1; clear_log();
    fork
      begin
        logic [31:0] d; int lat, idx, gap;
        for (int n = 0; n < 16; n++) begin
          idx = $urandom_range(0, 63);
          drive_if(32'(idx) * 4, d, lat);
          checks++; if (d !== if_rom[idx]) begin
            errors++; $display("FAIL rnd_fetch n=%0d got=%h exp=%h", n, d, if_rom[idx]);
          end
          gap = $urandom_range(0, 2);
          repeat (gap) begin @(posedge CLK); #1; end
        end
      end
      begin
        logic [31:0] d, wd; int lat, idx, gap;
        logic [2:0] wr;
        for (int n = 0; n < 16; n++) begin
          idx = $urandom_range(0, 7);
          if ($urandom_range(0, 1) == 1) begin
            wd = $urandom;
            wr = {1'b1, 2'($urandom_range(0, 2))};
            drive_ma(32'h2000 + 32'(idx) * 4, wd, RD_NONE, wr, d, lat);
            ma_model[idx] = wd;
          end else begin
            drive_ma(32'h2000 + 32'(idx) * 4, 32'h0, rd_codes[$urandom_range(0, 4)], WR_NONE, d, lat);
            checks++; if (d !== ma_model[idx]) begin
              errors++; $display("FAIL rnd_load n=%0d idx=%0d got=%h exp=%h", n, idx, d, ma_model[idx]);
            end
          end
          gap = $urandom_range(0, 2);
          repeat (gap) begin @(posedge CLK); #1; end
        end
      end
    join
    mem_rand_waits = 0;
    checks++; if (log_rd.size() != 32) begin
      errors++; $display("FAIL rnd_access_count got=%0d exp=32", log_rd.size());
    end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    RST = 1'b0; IF_REQ = 1'b0; IF_ADDR = '0;
    MA_ADDR = '0; MA_WDATA = '0; MA_READ = RD_NONE; MA_WRITE = WR_NONE;
    test_reset();
    test_if_only();
    test_simultaneous();
    test_wait_states();
    test_reset_mid_access();
    test_withdraw();
    test_priority();
    test_random();
    repeat (2) @(posedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    checks++; errors++;
    $display("FAIL watchdog simulation did not complete within 500000 time units");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one unified memory port (same read/write/busywait protocol as dmem) between the CPU's IF stage (instruction fetch) and MA stage (data access).
- Sits between cpu and a single memory instance; cpu stalls on the OR of the two per-requester busywaits.
- Fixed-priority or fair arbitration, one outstanding transaction, registered response.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width of all ports
IF_RD_CODE, 4'b1010, MEM_READ code driven for fetches (valid + LW)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous, active-low reset (sampled on rising CLK; 0 = reset)
IF_ADDR  in  ADDR_WIDTH  fetch address (PC)
IF_REQ  in  1  fetch request, held until IF_BUSYWAIT low
IF_DATA  out  DATA_WIDTH  fetched instruction
IF_BUSYWAIT  out  1  fetch stall
MA_ADDR  in  ADDR_WIDTH  data address
MA_WDATA  in  DATA_WIDTH  store data
MA_READ  in  4  [3]=valid, [2:0]=funct3 (LB/LH/LW/LBU/LHU)
MA_WRITE  in  3  [2]=valid, [1:0]=size (00 B, 01 H, 10 W)
MA_RDATA  out  DATA_WIDTH  load data
MA_BUSYWAIT  out  1  data stall
MEM_ADDR  out  ADDR_WIDTH  downstream address
MEM_WDATA  out  DATA_WIDTH  downstream store data
MEM_READ  out  4  downstream read code
MEM_WRITE  out  3  downstream write code
MEM_RDATA  in  DATA_WIDTH  downstream read data
MEM_BUSYWAIT  in  1  downstream busy

Behaviour:
- Reset (RST=0 at edge): state IDLE; MEM_READ=0, MEM_WRITE=0, MEM_ADDR=0, MEM_WDATA=0, IF_DATA=0, MA_RDATA=0. RST overrides any in-flight access. Downstream controls are 0 from the cycle after the reset edge.
- MA request = MA_READ[3] | MA_WRITE[2]. If both are set, the write is performed and the read is ignored.
- States:
  - IDLE: MA request → latch addr/wdata/codes, go MA_ACC. Else IF_REQ → latch IF_ADDR, go IF_ACC. Else stay.
  - MA_ACC / IF_ACC: MEM_* driven from latched values; IF uses MEM_READ=IF_RD_CODE, MEM_WRITE=0.
    - MEM_BUSYWAIT is ignored in the first ACC cycle, because memory raises it one cycle after the request.
    - From the 2nd ACC cycle, an edge with MEM_BUSYWAIT=0 completes the access: MEM_READ/MEM_WRITE go 0, MEM_RDATA is registered into IF_DATA or MA_RDATA (stores leave MA_RDATA unchanged), next state MA_RSP / IF_RSP.
  - MA_RSP / IF_RSP: lasts 1 cycle. The served requester's BUSYWAIT=0. Next state IDLE, or a direct grant per the IDLE rules to save a cycle.
- X_BUSYWAIT = X request active AND NOT (state == X_RSP). This is combinational, so a new request stalls in its first cycle.
- Minimum latency is 3 cycles from request to BUSYWAIT low (IDLE→ACC→ACC→RSP with zero-wait memory).
- Simultaneous IF and MA requests in IDLE: MA granted (older instruction).
- Request withdrawn mid-access: the downstream access still completes and the data register is updated. The RSP cycle is skipped and the next state is IDLE.
- Requester input changes during ACC are ignored (latched copies are used).
- IF_DATA and MA_RDATA hold their last value until the next completed read for that requester.

Optional Feature:
MEM_ARB_FAIR_EN
- Defined: a 1-bit last-grant flag is kept. After an MA completion, if IF_REQ is high, IF is granted next even if MA is requesting. Priority reverts to MA after the IF completion.
- Undefined: strict MA priority. IF may starve under back-to-back MA traffic, which is acceptable because MA stalls the pipeline.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum (IDLE, MA_ACC, IF_ACC, MA_RSP, IF_RSP);
  - read code constants (RD_LB..RD_LHU with valid bit) and write code constants (WR_SB/SH/SW);
  - RD_NONE=4'b0000 and WR_NONE=3'b000.
- No sub-module: FSM, latches and response registers are a single module of about 200 lines.

Test Plan:
- Reset: hold RST=0 for 2 cycles with IF_REQ=1 → MEM_READ=0, MEM_WRITE=0, IF_BUSYWAIT=1; release → MEM_READ=4'b1010 one cycle later.
- IF only: IF_ADDR=0x00000010, zero-wait memory returns 0x00500093 → IF_BUSYWAIT low exactly 3 cycles after request, IF_DATA=0x00500093.
- Simultaneous: IF_ADDR=0x14 and MA_WRITE=3'b110 @0x100 data 0xDEADBEEF → MEM_WRITE=3'b110 @0x100 first; then IF read @0x14; MA_BUSYWAIT drops before IF_BUSYWAIT.
- Wait states: memory busy for 4 cycles on MA_READ=4'b1010 @0x200 returning 0x12345678 → MA_BUSYWAIT high for 6 cycles, MA_RDATA=0x12345678.
- Reset mid-access: RST=0 in 2nd MA_ACC cycle → MEM_WRITE=0 next cycle, state IDLE, MA_RDATA=0.
- MEM_ARB_FAIR_EN: MA requests back-to-back with IF_REQ=1 → grant order MA, IF, MA; without the macro: MA, MA, ... until MA idles.
